// File: rtl/prog_chain_pkg.sv
// Shared types for the programming-chain segment: FSM state encoding and counter sizing.
package prog_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PROG   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Enough bits to hold every value from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/prog_chain_sreg.sv
// Word-wide shift register for one chain segment, with a registered tail output
// and a circular mode used for readback.
module prog_chain_sreg #(
    parameter int DIN_WIDTH = 1,
    parameter int DEPTH     = 64
) (
    input  logic                           prog_clk,
    input  logic                           prog_rst_n,
    input  logic                           shift_en,
    input  logic                           circ_en,
    input  logic [DIN_WIDTH-1:0]           din,
    output logic [DIN_WIDTH-1:0]           dout,
    output logic [DIN_WIDTH*DEPTH-1:0]     data
);

    localparam int W = DIN_WIDTH * DEPTH;

    logic [W-1:0]         data_q, data_d;
    logic [DIN_WIDTH-1:0] dout_q, dout_d;
    logic [DIN_WIDTH-1:0] tail;
    logic [DIN_WIDTH-1:0] head;

    // Oldest word sits at the MSB end, so after DEPTH shifts the first word is in the top slot.
    assign tail = data_q[W-1 -: DIN_WIDTH];
    assign head = circ_en ? tail : din;

    always_comb begin
        data_d = data_q;
        dout_d = dout_q;
        if (shift_en) begin
            data_d = (data_q << DIN_WIDTH) | W'(head);
            dout_d = tail;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            data_q <= '0;
            dout_q <= '0;
        end else begin
            data_q <= data_d;
            dout_q <= dout_d;
        end
    end

    assign data = data_q;
    assign dout = dout_q;

endmodule

// File: rtl/prog_chain_seg.sv
// One segment of the configuration programming chain: shifts the bitstream through,
// commits a full fill to cfg_q on the prog_done rising edge, and supports readback.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | after reset, waiting for the first word
//   ST_PROG   | shifting words in, counting fill
//   ST_COMMIT | one cycle: load cfg_q if full, else flag underfill
//   ST_DONE   | configuration live; prog_we does circular readback
module prog_chain_seg
    import prog_chain_pkg::*;
#(
    parameter int DIN_WIDTH    = 1,
    parameter int NUM_CFG_BITS = 64
) (
    input  logic                    prog_clk,
    input  logic                    prog_rst_n,
    input  logic                    prog_done,
    input  logic                    prog_we,
    input  logic [DIN_WIDTH-1:0]    prog_din,
    output logic [DIN_WIDTH-1:0]    prog_dout,
    output logic                    prog_we_o,
    output logic [NUM_CFG_BITS-1:0] cfg_q,
    output logic                    cfg_valid,
    output logic                    cfg_err
);

    localparam int DEPTH = NUM_CFG_BITS / DIN_WIDTH;
    localparam int CNT_W = cnt_width(DEPTH);

    state_e                  state_q, state_d;
    logic                    done_q;
    logic                    done_rise;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_CFG_BITS-1:0] cfg_data_q;
    logic                    valid_q, err_q, we_o_q;
    logic [NUM_CFG_BITS-1:0] sreg_data;

    logic shift_en, circ_en, cnt_inc, cnt_clr, commit_en;

    assign done_rise = prog_done & ~done_q;

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (done_rise)    state_d = ST_COMMIT;
                else if (prog_we) state_d = ST_PROG;
            end
            ST_PROG:   if (done_rise) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   if (!prog_done) state_d = ST_PROG;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_en  = 1'b0;
        circ_en   = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_PROG: begin
                shift_en = prog_we;
                cnt_inc  = prog_we;
            end
            ST_COMMIT: commit_en = 1'b1;
            ST_DONE: begin
                shift_en = prog_we;
                circ_en  = 1'b1;
                cnt_clr  = ~prog_done;
            end
            default: ;
        endcase
    end

    // Saturate rather than wrap: upstream segments legitimately see more than DEPTH words.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (cnt_inc && (cnt_q != CNT_W'(DEPTH)))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            done_q     <= 1'b0;
            cnt_q      <= '0;
            we_o_q     <= 1'b0;
            cfg_data_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= prog_done;
            cnt_q  <= cnt_d;
            we_o_q <= prog_we & (state_q != ST_COMMIT);
            if (commit_en) begin
                if (cnt_q == CNT_W'(DEPTH)) begin
                    cfg_data_q <= sreg_data;
                    valid_q    <= 1'b1;
                    err_q      <= 1'b0;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    prog_chain_sreg #(
        .DIN_WIDTH (DIN_WIDTH),
        .DEPTH     (DEPTH)
    ) u_sreg (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .shift_en   (shift_en),
        .circ_en    (circ_en),
        .din        (prog_din),
        .dout       (prog_dout),
        .data       (sreg_data)
    );

    assign prog_we_o = we_o_q;
    assign cfg_q     = cfg_data_q;
    assign cfg_valid = valid_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_prog_chain_seg.sv
// Bench for prog_chain_seg (4-bit words, 16 cfg bits): directed scenarios then
// randomized program/commit/readback sessions against a word-queue model.
module tb_prog_chain_seg;
    import prog_chain_pkg::*;

    localparam int DW    = 4;
    localparam int NB    = 16;
    localparam int DEPTH = NB / DW;

    logic          prog_clk = 1'b0;
    logic          prog_rst_n = 1'b0;
    logic          prog_done = 1'b0;
    logic          prog_we = 1'b0;
    logic [DW-1:0] prog_din = '0;
    logic [DW-1:0] prog_dout;
    logic          prog_we_o;
    logic [NB-1:0] cfg_q;
    logic          cfg_valid;
    logic          cfg_err;

    prog_chain_seg #(.DIN_WIDTH(DW), .NUM_CFG_BITS(NB)) dut (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .prog_done  (prog_done),
        .prog_we    (prog_we),
        .prog_din   (prog_din),
        .prog_dout  (prog_dout),
        .prog_we_o  (prog_we_o),
        .cfg_q      (cfg_q),
        .cfg_valid  (cfg_valid),
        .cfg_err    (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Reference model: the chain as a FIFO of words, oldest first.
    logic [DW-1:0] mq[$];
    int            m_cnt;
    logic [NB-1:0] m_cfg;
    logic          m_valid, m_err, m_we_o;
    logic [DW-1:0] m_dout;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NB-1:0] m_pack();
        logic [NB-1:0] r = '0;
        for (int i = 0; i < DEPTH; i++) r = (r << DW) | NB'(mq[i]);
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".dout"},  32'(prog_dout), 32'(m_dout));
        chk({tag, ".we_o"},  32'(prog_we_o), 32'(m_we_o));
        chk({tag, ".cfg"},   32'(cfg_q),     32'(m_cfg));
        chk({tag, ".valid"}, 32'(cfg_valid), 32'(m_valid));
        chk({tag, ".err"},   32'(cfg_err),   32'(m_err));
    endtask

    task automatic step();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < DEPTH; i++) mq.push_back('0);
        m_cnt = 0; m_cfg = '0; m_valid = 0; m_err = 0; m_we_o = 0; m_dout = '0;
    endtask

    task automatic do_reset(input string tag);
        prog_we    = 1'b0;
        prog_done  = 1'b0;
        prog_rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        chk({tag, ".state"}, 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge prog_clk);
        prog_rst_n = 1'b1;
    endtask

    task automatic shift(input logic [DW-1:0] w);
        prog_we  = 1'b1;
        prog_din = w;
        step();
        mq.push_back(w);
        m_dout = mq.pop_front();
        m_we_o = 1'b1;
        if (m_cnt < DEPTH) m_cnt++;
        prog_we = 1'b0;
        check_all("shift");
    endtask

    task automatic idle_cycle();
        prog_we  = 1'b0;
        prog_din = DW'($urandom);
        step();
        m_we_o = 1'b0;
        check_all("idle");
    endtask

    task automatic commit(input bit with_word, input logic [DW-1:0] w, input bit we_in_commit);
        prog_done = 1'b1;
        prog_we   = with_word;
        prog_din  = w;
        step();
        if (with_word) begin
            mq.push_back(w);
            m_dout = mq.pop_front();
            if (m_cnt < DEPTH) m_cnt++;
        end
        m_we_o = with_word;
        check_all("commit_e");
        prog_we  = we_in_commit;
        prog_din = DW'($urandom);
        step();
        m_we_o = 1'b0;
        if (m_cnt == DEPTH) begin
            m_cfg = m_pack(); m_valid = 1'b1; m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        prog_we = 1'b0;
        check_all("commit_e1");
    endtask

    task automatic readback();
        logic [DW-1:0] t;
        prog_we  = 1'b1;
        prog_din = DW'($urandom);
        step();
        t = mq.pop_front();
        mq.push_back(t);
        m_dout = t;
        m_we_o = 1'b1;
        prog_we = 1'b0;
        check_all("readback");
    endtask

    task automatic reprog();
        prog_done = 1'b0;
        prog_we   = 1'b0;
        step();
        m_we_o = 1'b0;
        m_cnt  = 0;
        check_all("reprog");
    endtask

    initial begin
        model_reset();
        do_reset("reset0");

        // Nominal fill and commit.
        shift(4'h1); shift(4'h2); shift(4'h3); shift(4'h4);
        commit(1'b0, 4'h0, 1'b1);
        chk("nom.cfg", 32'(cfg_q), 32'h1234);
        chk("nom.valid", 32'(cfg_valid), 32'd1);
        chk("nom.err", 32'(cfg_err), 32'd0);

        // Readback twice must produce the same word order.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                readback();
                chk("rb.word", 32'(prog_dout), 32'(k + 1));
            end
            chk("rb.cfg", 32'(cfg_q), 32'h1234);
        end

        // Reprogramming keeps the old config until the new commit.
        reprog();
        shift(4'hA); shift(4'hB); shift(4'hC);
        chk("reprog.hold", 32'(cfg_q), 32'h1234);
        shift(4'hD);
        commit(1'b0, 4'h0, 1'b0);
        chk("reprog.cfg", 32'(cfg_q), 32'hABCD);

        // Async reset in the middle of a fill.
        reprog();
        shift(4'h5); shift(4'h6);
        do_reset("rst_mid");

        // Underfill.
        shift(4'h1); shift(4'h2); shift(4'h3);
        commit(1'b0, 4'h0, 1'b0);
        chk("under.err", 32'(cfg_err), 32'd1);
        chk("under.valid", 32'(cfg_valid), 32'd0);
        chk("under.cfg", 32'(cfg_q), 32'h0000);

        // Pass-through overfill.
        do_reset("reset1");
        for (int k = 1; k <= 4; k++) shift(DW'(k));
        shift(4'h5);
        chk("pt.dout1", 32'(prog_dout), 32'h1);
        shift(4'h6);
        chk("pt.dout2", 32'(prog_dout), 32'h2);
        commit(1'b0, 4'h0, 1'b0);
        chk("pt.cfg", 32'(cfg_q), 32'h3456);
        chk("pt.err", 32'(cfg_err), 32'd0);

        // Commit with a shift on the same edge as the prog_done rise.
        reprog();
        shift(4'h7); shift(4'h8); shift(4'h9);
        commit(1'b1, 4'hE, 1'b1);
        chk("same_edge.cfg", 32'(cfg_q), 32'h789E);

        // Randomized sessions.
        reprog();
        for (int it = 0; it < 30; it++) begin
            int n;
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                shift(DW'($urandom));
            end
            commit(1'($urandom), DW'($urandom), 1'($urandom));
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) idle_cycle();
                readback();
            end
            if ($urandom_range(0, 5) == 0) do_reset("rst_rand");
            else reprog();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
